// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: column drive, row synchronizer, per-scan key
// decode and debounce, producing a committed key code plus a level held flag.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec,
  output logic       button_pressed
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [NW-1:0] CNT_MAX  = NW'(DEBOUNCE_SCANS);

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]          sync1_q, sync2_q;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [1:0]          ci_q, ci_d;
  logic [3:0]          col_q, col_d;
  logic [3:0][3:0]     cap_q, cap_d;   // [column][row], 1 = key closed
  logic [4:0]          cand_q, cand_d;
  logic [NW-1:0]       cnt_q, cnt_d, cnt_nx;
  logic [3:0]          dec_q, dec_d;
  logic                bp_q, bp_d;

  logic                capture, scan_end, changed, commit;
  logic [4:0]          nkeys;
  logic [3:0]          hit_code;
  logic [4:0]          raw;

  always_comb begin
    capture  = (cyc_q == CYC_LAST);
    scan_end = capture && (ci_q == 2'd3);
    cyc_d    = capture ? '0 : cyc_q + CW'(1);
    ci_d     = capture ? ci_q + 2'd1 : ci_q;
    col_d    = ~(4'b0001 << ci_d);
    cap_d    = cap_q;
    if (capture) cap_d[ci_q] = ~sync2_q;
  end

  // Decode the full matrix, including the column captured on this very edge.
  always_comb begin
    nkeys    = '0;
    hit_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (cap_d[c][r]) begin
          nkeys    = nkeys + 5'd1;
          hit_code = key_code(2'(r), 2'(c));
        end
      end
    end
    raw = (nkeys == 5'd1) ? {1'b1, hit_code} : 5'b0;
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    bp_d    = bp_q;
    changed = 1'b0;
    commit  = 1'b0;
    cnt_nx  = cnt_q;
    if (scan_end) begin
      changed = (raw != cand_q);
      if (changed) begin
        cand_d = raw;
        cnt_nx = NW'(1);
      end else begin
        cnt_nx = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + NW'(1);
      end
      commit = (cnt_nx == CNT_MAX) && (changed || cnt_q != CNT_MAX);
      cnt_d  = cnt_nx;
      if (commit) begin
        if (cand_d[4] && !bp_q) begin
          dec_d = cand_d[3:0];
          bp_d  = 1'b1;
        end else if (!cand_d[4]) begin
          bp_d = 1'b0;
        end else if (cand_d[3:0] != dec_q) begin
          // Drop the flag and re-count so the new key gets its own rising edge.
          bp_d  = 1'b0;
          cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
      cyc_q   <= '0;
      ci_q    <= '0;
      col_q   <= 4'b1110;
      cap_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      dec_q   <= 4'h0;
      bp_q    <= 1'b0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      cyc_q   <= cyc_d;
      ci_q    <= ci_d;
      col_q   <= col_d;
      cap_q   <= cap_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      bp_q    <= bp_d;
    end
  end

  assign col            = col_q;
  assign dec            = dec_q;
  assign button_pressed = bp_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model driving rows from the column drive,
// per-scan reference model of decode/debounce, directed plan plus random presses.
module tb_keypad_scanner;
  localparam int SC   = 8;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col, dec;
  logic        button_pressed;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c is closed

  int checks = 0;
  int errors = 0;
  int t = 0;                // edges since reset release
  int m_dec, m_bp, m_cand, m_cnt;
  int key_val [16];

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .dec(dec),
    .button_pressed(button_pressed)
  );

  always #5 clk = ~clk;

  // Membrane: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [15:0] kmask(input int code);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (key_val[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    m_dec = 0; m_bp = 0; m_cand = -1; m_cnt = 0;
  endtask

  // One whole scan seen with a constant key set.
  task automatic model_scan(input logic [15:0] k);
    int pop, raw, nc;
    bit ch, cm;
    pop = 0; raw = -1;
    for (int i = 0; i < 16; i++)
      if (k[i]) begin pop++; raw = key_val[i]; end
    if (pop != 1) raw = -1;
    ch = (raw != m_cand);
    if (ch) begin m_cand = raw; nc = 1; end
    else nc = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
    cm = (nc == DB) && (ch || m_cnt != DB);
    m_cnt = nc;
    if (cm) begin
      if (m_cand >= 0 && m_bp == 0) begin m_dec = m_cand; m_bp = 1; end
      else if (m_cand < 0) m_bp = 0;
      else if (m_cand != m_dec) begin m_bp = 0; m_cnt = 0; end
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    @(posedge clk); #1;
    if (rst) begin
      t = 0;
      model_reset();
    end else begin
      t++;
      if (t % SCAN == 0) model_scan(keys);
    end
    ec = ~(4'b0001 << ((t / SC) % 4));
    check("col", col, ec);
    check("dec", dec, m_dec);
    check("button_pressed", button_pressed, m_bp);
  endtask

  task automatic scans(input logic [15:0] m, input int n);
    keys = m;
    repeat (n * SCAN) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] k1, k2, k5, ka, kb, m;
    key_val = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
    k1 = kmask(1); k2 = kmask(2); k5 = kmask(5); ka = kmask(10); kb = kmask(11);

    // 1: reset and idle column walk
    do_reset(3);
    check("rst_col", col, 4'b1110);
    check("rst_dec", dec, 4'h0);
    check("rst_bp", button_pressed, 1'b0);
    repeat (8) tick();
    check("col_after8", col, 4'b1101);
    repeat (24) tick();
    check("col_after32", col, 4'b1110);

    // 2: key 5 held from cycle 0
    keys = k5;
    do_reset(1);
    scans(k5, 1);
    check("press5_scan1_bp", button_pressed, 1'b0);
    scans(k5, 1);
    check("press5_edge64_bp", button_pressed, 1'b1);
    check("press5_edge64_dec", dec, 4'h5);
    scans(k5, 2);
    check("hold5_bp", button_pressed, 1'b1);

    // 3: release
    scans('0, 1);
    check("rel_scan1_bp", button_pressed, 1'b1);
    scans('0, 1);
    check("rel_scan2_bp", button_pressed, 1'b0);
    check("rel_dec", dec, 4'h5);

    // 4: bounce on key A
    for (int i = 0; i < 8; i++) begin
      scans((i % 2 == 0) ? ka : 16'h0, 1);
      check("bounce_bp", button_pressed, 1'b0);
    end
    check("bounce_dec", dec, 4'h5);

    // 5: chord, then single key 1
    scans(k1 | k2, 6);
    check("chord_bp", button_pressed, 1'b0);
    check("chord_dec", dec, 4'h5);
    scans(k1, 1);
    check("k1_scan1_bp", button_pressed, 1'b0);
    scans(k1, 1);
    check("k1_bp", button_pressed, 1'b1);
    check("k1_dec", dec, 4'h1);

    // 6: key 5 straight to key B, then reset mid-scan
    scans('0, 2);
    scans(k5, 2);
    check("k5_bp", button_pressed, 1'b1);
    check("k5_dec", dec, 4'h5);
    scans(kb, 2);
    check("kb_fall_bp", button_pressed, 1'b0);
    check("kb_fall_dec", dec, 4'h5);
    scans(kb, 2);
    check("kb_rise_bp", button_pressed, 1'b1);
    check("kb_rise_dec", dec, 4'hB);
    repeat (13) tick();
    rst = 1'b1;
    tick();
    check("midrst_col", col, 4'b1110);
    check("midrst_dec", dec, 4'h0);
    check("midrst_bp", button_pressed, 1'b0);
    rst = 1'b0;

    // Random presses, releases, chords and short holds
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1, 3:    m = 16'(1) << $urandom_range(0, 15);
        default: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      scans(m, int'($urandom_range(1, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
